// File: rtl/inst_axi_bridge.sv
// Instruction-side bridge: SRAM-like fetch port to a single-beat, read-only AXI4 master.
// Responses return in order; up to MAX_OUTST reads may be accepted and not yet returned.
module inst_axi_bridge #(
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [3:0]  ARID_VAL  = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_t;

    localparam logic [1:0] MAX_OUTST_C = MAX_OUTST[1:0];

    ar_state_t   ar_state_r;
    logic [1:0]  outst_r;
    logic [31:0] araddr_r;
    logic [2:0]  arsize_r;
    logic        addr_ok_s;
    logic        r_hs_s;
    logic        rready_s;
    logic        unused_inputs_s;

    assign rready_s = (outst_r != 2'd0);

    // Acceptance decode; a retiring response frees its slot in the same cycle
    always_comb begin
        r_hs_s = rvalid & rready_s;
        if (reset) begin
            addr_ok_s = 1'b0;
        end else if (ar_state_r != AR_IDLE) begin
            addr_ok_s = 1'b0;
        end else if ((outst_r < MAX_OUTST_C) || r_hs_s) begin
            addr_ok_s = inst_sram_req;
        end else begin
            addr_ok_s = 1'b0;
        end
    end

    // AR state machine and outstanding-read counter
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state_r <= AR_IDLE;
            outst_r    <= 2'd0;
        end else begin
            case (ar_state_r)
                AR_IDLE: begin
                    if (addr_ok_s) begin
                        ar_state_r <= AR_SEND;
                    end
                end
                AR_SEND: begin
                    if (arready) begin
                        ar_state_r <= AR_IDLE;
                    end
                end
                default: ar_state_r <= AR_IDLE;
            endcase

            case ({addr_ok_s, r_hs_s})
                2'b10:   outst_r <= outst_r + 2'd1;
                2'b01:   outst_r <= outst_r - 2'd1;
                default: outst_r <= outst_r;
            endcase
        end
    end

    // AR payload capture; word-aligned so misaligned fetches never reach the bus
    always_ff @(posedge clk) begin
        if (addr_ok_s) begin
            araddr_r <= {inst_sram_addr[31:2], 2'b00};
            arsize_r <= {1'b0, inst_sram_size};
        end
    end

    assign inst_sram_addr_ok = addr_ok_s;
    assign inst_sram_data_ok = r_hs_s;
    assign inst_sram_rdata   = rdata;

    assign arid    = ARID_VAL;
    assign araddr  = araddr_r;
    assign arlen   = 8'd0;
    assign arsize  = arsize_r;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = (ar_state_r == AR_SEND);
    assign rready  = rready_s;

    assign unused_inputs_s = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

endmodule
